// File: rtl/multicycle_ctrl.sv
// Control sequencer for the multi-cycle datapath: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives register enables and memory requests.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_WIDTH    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] op_class,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       pc_en,
   output logic [1:0] pc_sel,
   output logic       ir_en,
   output logic       ab_en,
   output logic       alu_out_en,
   output logic       mdr_en,
   output logic       rf_we,
   output logic       wb_sel,
   output logic       instr_retired,
   output logic       halted,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   localparam logic [2:0] C_ALU    = 3'd0;
   localparam logic [2:0] C_LOAD   = 3'd1;
   localparam logic [2:0] C_STORE  = 3'd2;
   localparam logic [2:0] C_BRANCH = 3'd3;
   localparam logic [2:0] C_JUMP   = 3'd4;
   localparam logic [2:0] C_HALT   = 3'd7;

   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [2:0]          cls_q, cls_d;
   logic [TO_WIDTH-1:0] wcnt_q, wcnt_d;
   logic                wait_expired;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cls_q   <= 3'd0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cls_d         = cls_q;
      wcnt_d        = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      pc_en         = 1'b0;
      pc_sel        = 2'd0;
      ir_en         = 1'b0;
      ab_en         = 1'b0;
      alu_out_en    = 1'b0;
      mdr_en        = 1'b0;
      rf_we         = 1'b0;
      wb_sel        = 1'b0;
      instr_retired = 1'b0;
      halted        = 1'b0;
      fault         = 1'b0;
      wait_expired  = (MEM_TIMEOUT != 0) && (wcnt_q == TO_LAST);

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_en   = 1'b1;
               pc_en   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            ab_en = 1'b1;
            cls_d = op_class;
            case (op_class)
               C_HALT:       state_d = S_HALT;
               C_JUMP: begin
                  pc_en         = 1'b1;
                  pc_sel        = 2'd2;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end
               3'd5, 3'd6:   state_d = S_FAULT;
               default:      state_d = S_EXECUTE;
            endcase
         end
         S_EXECUTE: begin
            alu_out_en = 1'b1;
            case (cls_q)
               C_ALU:           state_d = S_WRITEBACK;
               C_LOAD, C_STORE: state_d = S_MEM;
               C_BRANCH: begin
                  pc_en         = branch_taken;
                  pc_sel        = 2'd1;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end
               default:         state_d = S_FAULT;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (cls_q == C_STORE);
            if (mem_ready) begin
               if (cls_q == C_LOAD) begin
                  mdr_en  = 1'b1;
                  state_d = S_WRITEBACK;
               end else begin
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_WRITEBACK: begin
            rf_we         = 1'b1;
            wb_sel        = (cls_q == C_LOAD);
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         S_FAULT: begin
            halted = 1'b1;
            fault  = 1'b1;
         end
         default: state_d = S_FAULT;
      endcase

      // While reset is held the register sits in FETCH; only the request stays visible.
      if (reset) begin
         ir_en = 1'b0;
         pc_en = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds each instruction's expected cycle timeline
// from the latency/wait rules and compares every cycle against the DUT.
module tb_multicycle_ctrl;

   localparam int TO = 4;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, addr_sel, pc_en;
      logic [1:0] pc_sel;
      logic       ir_en, ab_en, alu_out_en, mdr_en, rf_we, wb_sel, retired, halted, fault;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] op_class = 3'd0;
   logic       branch_taken = 1'b0;
   logic       mem_ready = 1'b1;
   logic       mem_req, mem_we, addr_sel, pc_en, ir_en, ab_en, alu_out_en;
   logic       mdr_en, rf_we, wb_sel, instr_retired, halted, fault;
   logic [1:0] pc_sel;
   logic [2:0] state;

   obs_t act, exp_cur;
   logic chk_en = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   retire_cnt = 0;
   int   ncyc = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .op_class(op_class), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .pc_en(pc_en), .pc_sel(pc_sel), .ir_en(ir_en), .ab_en(ab_en),
      .alu_out_en(alu_out_en), .mdr_en(mdr_en), .rf_we(rf_we), .wb_sel(wb_sel),
      .instr_retired(instr_retired), .halted(halted), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {state, mem_req, mem_we, addr_sel, pc_en, pc_sel, ir_en, ab_en,
                 alu_out_en, mdr_en, rf_we, wb_sel, instr_retired, halted, fault};

   // Output rules for one cycle spent in a given phase.
   function automatic obs_t rule(input logic [2:0] st, input logic [2:0] c,
                                 input logic bt, input logic rdy);
      obs_t o;
      o = '0;
      o.st = st;
      case (st)
         3'd0: begin o.mem_req = 1'b1; o.ir_en = rdy; o.pc_en = rdy; end
         3'd1: begin
            o.ab_en = 1'b1;
            if (c == 3'd4) begin o.pc_en = 1'b1; o.pc_sel = 2'd2; o.retired = 1'b1; end
         end
         3'd2: begin
            o.alu_out_en = 1'b1;
            if (c == 3'd3) begin o.pc_en = bt; o.pc_sel = 2'd1; o.retired = 1'b1; end
         end
         3'd3: begin
            o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (c == 3'd2);
            if (rdy) begin
               if (c == 3'd1) o.mdr_en = 1'b1;
               else o.retired = 1'b1;
            end
         end
         3'd4: begin o.rf_we = 1'b1; o.wb_sel = (c == 3'd1); o.retired = 1'b1; end
         3'd5: o.halted = 1'b1;
         3'd6: begin o.halted = 1'b1; o.fault = 1'b1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.mem_req = 1'b1;
      return o;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (act !== exp_cur) begin
            bad++;
            $display("FAIL cycle t=%0t act=%h exp=%h (state act=%0d exp=%0d)",
                     $time, act, exp_cur, act.st, exp_cur.st);
         end
         if (act.retired) retire_cnt++;
      end
   end

   task automatic chk(input string name, input int a, input int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", name, a, e);
      end
   endtask

   task automatic chk_obs(input string name, input obs_t e);
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, e);
      end
   endtask

   // Called at posedge+1; leaves at the next posedge+1.
   task automatic step(input logic [2:0] st, input logic [2:0] c, input logic bt,
                       input logic rdy, input logic [2:0] opd, input logic btd,
                       input logic mrd);
      op_class = opd;
      branch_taken = btd;
      mem_ready = mrd;
      exp_cur = rule(st, c, bt, rdy);
      chk_en = 1'b1;
      ncyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string name);
      chk_en = 1'b0;
      mem_ready = 1'b1;
      op_class = 3'($urandom_range(0, 7));
      reset = 1'b1;
      #1;
      chk_obs(name, reset_obs());
      @(posedge clk);
      #1;
      chk_obs({name, "_held"}, reset_obs());
      reset = 1'b0;
   endtask

   task automatic park(input logic [2:0] st);
      for (int k = 0; k < 3; k++)
         step(st, 3'd0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      do_reset("park_reset");
   endtask

   // kind: 0 retired normally, 1 halt/fault, 2 aborted by reset
   task automatic run_instr(input logic [2:0] c, input logic bt, input int wf,
                            input int wm, input int rst_at, output int cyc, output int kind);
      logic rdy;
      ncyc = 0;
      kind = 1;
      for (int i = 0; i <= wf; i++) begin
         rdy = (i == wf);
         step(3'd0, c, bt, rdy, 3'($urandom_range(0, 7)), 1'($urandom), rdy);
         if (!rdy && i == TO - 1) begin park(3'd6); cyc = ncyc; return; end
      end
      step(3'd1, c, bt, 1'b0, c, 1'($urandom), 1'($urandom));
      if (c == 3'd7) begin park(3'd5); cyc = ncyc; return; end
      if (c == 3'd5 || c == 3'd6) begin park(3'd6); cyc = ncyc; return; end
      kind = 0;
      if (c == 3'd4) begin cyc = ncyc; return; end
      step(3'd2, c, bt, 1'b0, 3'($urandom_range(0, 7)), bt, 1'($urandom));
      if (c == 3'd3) begin cyc = ncyc; return; end
      if (c == 3'd1 || c == 3'd2) begin
         for (int j = 0; j <= wm; j++) begin
            if (j == rst_at) begin
               kind = 2;
               cyc = ncyc;
               do_reset("mid_mem_reset");
               return;
            end
            rdy = (j == wm);
            step(3'd3, c, bt, rdy, 3'($urandom_range(0, 7)), 1'($urandom), rdy);
            if (!rdy && j == TO - 1) begin kind = 1; park(3'd6); cyc = ncyc; return; end
         end
         if (c == 3'd2) begin cyc = ncyc; return; end
      end
      step(3'd4, c, bt, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      cyc = ncyc;
   endtask

   task automatic directed(input string name, input logic [2:0] c, input logic bt,
                           input int wf, input int wm, input int rst_at,
                           input int exp_cyc, input int exp_kind);
      int cyc, kind, r0;
      r0 = retire_cnt;
      run_instr(c, bt, wf, wm, rst_at, cyc, kind);
      chk({name, "_cycles"}, cyc, exp_cyc);
      chk({name, "_kind"}, kind, exp_kind);
      chk({name, "_retired"}, retire_cnt - r0, (exp_kind == 0) ? 1 : 0);
   endtask

   initial begin
      int r, cyc, kind, r0, wf, wm, rst_at;
      logic [2:0] c;
      mem_ready = 1'b1;
      #3;
      chk_obs("reset_state", reset_obs());
      @(posedge clk);
      #1;
      reset = 1'b0;

      directed("alu", 3'd0, 1'b0, 0, 0, -1, 4, 0);
      directed("load_wait3", 3'd1, 1'b0, 0, 3, -1, 8, 0);
      directed("load", 3'd1, 1'b0, 0, 0, -1, 5, 0);
      directed("store", 3'd2, 1'b0, 0, 0, -1, 4, 0);
      directed("br_taken", 3'd3, 1'b1, 0, 0, -1, 3, 0);
      directed("br_not", 3'd3, 1'b0, 0, 0, -1, 3, 0);
      directed("jump", 3'd4, 1'b0, 0, 0, -1, 2, 0);
      directed("fetch_timeout", 3'd0, 1'b0, 4, 0, -1, 7, 1);
      directed("fetch_ready_last", 3'd0, 1'b0, 3, 0, -1, 7, 0);
      directed("mem_timeout", 3'd2, 1'b0, 0, 6, -1, 10, 1);
      directed("halt", 3'd7, 1'b0, 0, 0, -1, 5, 1);
      directed("reserved5", 3'd5, 1'b0, 0, 0, -1, 5, 1);
      directed("mem_reset", 3'd1, 1'b0, 0, 5, 2, 5, 2);
      directed("after_reset", 3'd0, 1'b0, 1, 0, -1, 5, 0);

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 19);
         if (r < 4) c = 3'd0;
         else if (r < 8) c = 3'd1;
         else if (r < 11) c = 3'd2;
         else if (r < 14) c = 3'd3;
         else if (r < 17) c = 3'd4;
         else if (r == 17) c = 3'd7;
         else if (r == 18) c = 3'd5;
         else c = 3'd6;
         r = $urandom_range(0, 9);
         wf = (r < 6) ? 0 : r - 5;
         r = $urandom_range(0, 9);
         wm = (r < 5) ? 0 : r - 5;
         rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (wm < TO) ? wm : TO - 1) : -1;
         r0 = retire_cnt;
         run_instr(c, 1'($urandom), wf, wm, rst_at, cyc, kind);
         chk("rand_retired", retire_cnt - r0, (kind == 0) ? 1 : 0);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
